// File: rtl/bkg_map_ram.sv
// bkg_map_ram: background tile map held in an internal array.
// After reset or a reload pulse the level image is copied from an external
// combinational ROM (one entry per cycle); afterwards the map serves
// renderer reads and acknowledged game-logic writes.
// Optional feature macro: BKG_WALL_GUARD_EN -- when defined, writes that
// target an entry currently holding the solid-wall code (6) are acknowledged
// but leave the entry unchanged.
module bkg_map_ram #(
    parameter int unsigned DEPTH = 300,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reload,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_q,
    output logic          ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        COPY = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];

    logic          wr_in_range;
    logic          rd_in_range;
    logic          wr_blocked;
    logic          accept;
    logic          copy_we;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // Address range qualification against the physical map size
    assign wr_in_range = 32'(wr_addr) < DEPTH;
    assign rd_in_range = 32'(rd_addr) < DEPTH;

`ifdef BKG_WALL_GUARD_EN
    localparam logic [DW-1:0] WALL_CODE = DW'(6);
    logic [AW-1:0] wr_idx;

    // Solid walls are protected: the write is acknowledged but dropped
    assign wr_idx     = wr_in_range ? wr_addr : '0;
    assign wr_blocked = (mem[wr_idx] == WALL_CODE);
`else
    assign wr_blocked = 1'b0;
`endif

    // A write is taken in RUN when no reload competes and the previous
    // acknowledge cycle has passed (one dead cycle between acceptances)
    assign accept  = (state == RUN) && wr_req && !reload && !wr_ack;

    // ROM copy writes one entry per cycle while copying; aborted by reset/reload
    assign copy_we = (state == COPY) && !reload && !rst;

    // Single write port shared by the copy engine and game-logic writes
    assign mem_we    = copy_we || (accept && wr_in_range && !wr_blocked);
    assign mem_waddr = copy_we ? rom_addr : wr_addr;
    assign mem_wdata = copy_we ? rom_q : wr_data;

    // Map storage; contents survive reset and are overwritten by the next copy
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port, read-before-write, out-of-range reads return 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (rd_in_range) begin
            rd_q <= mem[rd_addr];
        end else begin
            rd_q <= '0;
        end
    end

    // Copy/run control; rom_addr doubles as the copy counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COPY;
            rom_addr <= '0;
            ready    <= 1'b0;
            wr_ack   <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            if (reload) begin
                state    <= COPY;
                rom_addr <= '0;
                ready    <= 1'b0;
            end else begin
                case (state)
                    COPY: begin
                        if (rom_addr == LAST_ADDR) begin
                            state    <= RUN;
                            ready    <= 1'b1;
                            rom_addr <= '0;
                        end else begin
                            rom_addr <= rom_addr + AW'(1);
                        end
                    end
                    RUN: begin
                        ready    <= 1'b1;
                        rom_addr <= '0;
                        wr_ack   <= accept;
                    end
                    default: begin
                        state    <= COPY;
                        rom_addr <= '0;
                        ready    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bkg_map_ram.sv
// Self-checking bench for bkg_map_ram: cycle-level reference model of the
// tile map plus directed scenarios with hand-computed expectations.
module tb_bkg_map_ram;

    localparam int DEPTH = 300;
    localparam int AW    = 9;
    localparam int DW    = 3;

`ifdef BKG_WALL_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reload = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_q;
    logic          ready;

    int n_checks = 0;
    int n_errors = 0;

    bkg_map_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .reload   (reload),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_addr  (rd_addr),
        .rd_q     (rd_q),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    // Level image: entry 0 = 0, entry 1 = wall (6), others (5a mod 7)
    function automatic logic [DW-1:0] rom_val(input int a);
        if (a == 1) return 3'd6;
        return 3'((a * 5) % 7);
    endfunction

    assign rom_q = rom_val(int'(rom_addr));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: map contents, copy progress and ack behaviour
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    bit            m_copy = 1'b1;
    int            m_idx = 0;
    bit            m_ready = 1'b0;
    bit            m_ack = 1'b0;
    int            m_rdq = 0;
    bit            m_rdq_known = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_copy = 1'b1; m_idx = 0; m_ready = 1'b0; m_ack = 1'b0;
            m_rdq = 0; m_rdq_known = 1'b1;
        end else begin
            if (int'(rd_addr) >= DEPTH) begin
                m_rdq = 0; m_rdq_known = 1'b1;
            end else begin
                m_rdq = int'(ref_mem[rd_addr]); m_rdq_known = ref_known[rd_addr];
            end
            if (reload) begin
                m_copy = 1'b1; m_idx = 0; m_ready = 1'b0; m_ack = 1'b0;
            end else if (m_copy) begin
                ref_mem[m_idx] = rom_val(m_idx);
                ref_known[m_idx] = 1'b1;
                m_ack = 1'b0;
                if (m_idx == DEPTH - 1) begin
                    m_copy = 1'b0; m_ready = 1'b1; m_idx = 0;
                end else begin
                    m_idx++;
                end
            end else begin
                m_ack = wr_req && !m_ack;
                if (m_ack && int'(wr_addr) < DEPTH)
                    if (!(GUARD && ref_mem[wr_addr] == 3'd6))
                        ref_mem[wr_addr] = wr_data;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", int'(ready), int'(m_ready));
            chk("wr_ack", int'(wr_ack), int'(m_ack));
            chk("rom_addr", int'(rom_addr), m_copy ? m_idx : 0);
            if (m_rdq_known) chk("rd_q", int'(rd_q), m_rdq);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts cycles until ready rises, bounded
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        // Reset state
        step(3);
        chk("rst_ready", int'(ready), 0);
        chk("rst_rd_q", int'(rd_q), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);

        // Copy after reset takes exactly DEPTH cycles
        rst = 1'b0;
        wait_ready(n);
        chk("copy_len_reset", n, 300);
        rd_addr = 9'd1;
        step(1);
        chk("rd_wall", int'(rd_q), 6);
        rd_addr = 9'd0;
        step(1);
        chk("rd_entry0", int'(rd_q), 0);

        // Single write
        wr_req = 1'b1; wr_addr = 9'd0; wr_data = 3'd3;
        step(1);
        chk("ack_single", int'(wr_ack), 1);
        wr_req = 1'b0;
        step(1);
        chk("ack_one_cycle", int'(wr_ack), 0);
        step(1);
        chk("rd_after_write", int'(rd_q), 3);

        // Request held: accepted, ignored, accepted
        wr_req = 1'b1; wr_addr = 9'd5; wr_data = 3'd1;
        step(1); chk("held_ack0", int'(wr_ack), 1);
        step(1); chk("held_ack1", int'(wr_ack), 0);
        step(1); chk("held_ack2", int'(wr_ack), 1);
        wr_req = 1'b0;
        step(1); chk("held_ack3", int'(wr_ack), 0);

        // Read-before-write on the same address (entry 8 holds 5)
        rd_addr = 9'd8; wr_req = 1'b1; wr_addr = 9'd8; wr_data = 3'd2;
        step(1);
        chk("rbw_old", int'(rd_q), 5);
        chk("rbw_ack", int'(wr_ack), 1);
        wr_req = 1'b0;
        step(1);
        chk("rbw_new", int'(rd_q), 2);

        // Out-of-range write and read
        rd_addr = 9'd300; wr_req = 1'b1; wr_addr = 9'd300; wr_data = 3'd7;
        step(1);
        chk("oor_ack", int'(wr_ack), 1);
        chk("oor_rd", int'(rd_q), 0);
        wr_req = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            step(1);
        end

        // Write 0 over the wall at entry 1
        wr_req = 1'b1; wr_addr = 9'd1; wr_data = 3'd0;
        step(1);
        chk("wall_ack", int'(wr_ack), 1);
        wr_req = 1'b0; rd_addr = 9'd1;
        step(1);
        chk("wall_rd", int'(rd_q), GUARD ? 6 : 0);

        // Reload beats a simultaneous write; write stays pending through copy
        reload = 1'b1; wr_req = 1'b1; wr_addr = 9'd2; wr_data = 3'd4;
        step(1);
        chk("reload_no_ack", int'(wr_ack), 0);
        chk("reload_ready", int'(ready), 0);
        reload = 1'b0;
        wait_ready(n);
        chk("copy_len_reload", n, 300);
        step(1);
        chk("pending_ack", int'(wr_ack), 1);
        wr_req = 1'b0; rd_addr = 9'd2;
        step(1);
        step(1);
        chk("pending_data", int'(rd_q), 4);

        // Reload restarted at copy cycle 150
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        step(150);
        chk("mid_rom_addr", int'(rom_addr), 150);
        reload = 1'b1;
        step(1);
        reload = 1'b0;
        chk("restart_rom_addr", int'(rom_addr), 0);
        wait_ready(n);
        chk("copy_len_restart", n, 300);

        // Reset mid-copy aborts it; a pending write is not acknowledged early
        reload = 1'b1;
        step(1);
        reload = 1'b0; wr_req = 1'b1; wr_addr = 9'd3; wr_data = 3'd6;
        step(40);
        rst = 1'b1;
        #1;
        chk("async_rom_addr", int'(rom_addr), 0);
        chk("async_ready", int'(ready), 0);
        step(2);
        rst = 1'b0;
        wait_ready(n);
        chk("copy_len_rst", n, 300);
        step(1);
        chk("post_rst_ack", int'(wr_ack), 1);
        wr_req = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            step(1);
        end
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bkg_map_ram.md
BKG_MAP_RAM -- requirements
Module: bkg_map_ram

Interface
- REQ-001 SHALL have parameter DEPTH, default 300, meaning number of background tile entries (20 x 15 map).
- REQ-002 SHALL have parameter AW, default 9, meaning address width.
- REQ-003 SHALL have parameter DW, default 3, meaning tile code width.
- REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
- REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
- REQ-006 SHALL have port reload  input  1  single-cycle pulse that restarts the copy of the level image from ROM.
- REQ-007 SHALL have port rom_addr  output  AW  address driven to the combinational background ROM.
- REQ-008 SHALL have port rom_q  input  DW  tile code returned by the ROM in the same cycle.
- REQ-009 SHALL have port wr_req  input  1  game-logic write request, held high until acknowledged.
- REQ-010 SHALL have port wr_addr  input  AW  tile address to write.
- REQ-011 SHALL have port wr_data  input  DW  new tile code.
- REQ-012 SHALL have port wr_ack  output  1  one-cycle acknowledge of an accepted write.
- REQ-013 SHALL have port rd_addr  input  AW  renderer read address.
- REQ-014 SHALL have port rd_q  output  DW  registered read data.
- REQ-015 SHALL have port ready  output  1  high when the map holds a complete level image and accepts writes.

Function
- REQ-016 SHALL store DEPTH entries of DW bits in an internal array.
- REQ-017 SHALL implement a two-state FSM: COPY and RUN.
- REQ-018 In COPY: rom_addr = copy counter, rom_q written to mem[counter] each cycle, counter increments 0..DEPTH-1.
- REQ-019 SHALL transition COPY -> RUN on the edge that writes entry DEPTH-1; ready rises that same edge (copy takes exactly DEPTH cycles).
- REQ-020 In RUN: rom_addr SHALL hold 0; ready SHALL stay high.
- REQ-021 A reload pulse in either state SHALL set counter to 0, enter COPY, and drop ready on the next edge; a reload during COPY restarts the copy from 0.
- REQ-022 In RUN, with wr_req high and no reload, the write SHALL be committed and wr_ack asserted on the same edge; wr_ack high for exactly one cycle.
- REQ-023 The cycle after wr_ack, wr_req is ignored (new request accepted no sooner than two cycles after the previous acceptance).
- REQ-024 In COPY, wr_ack SHALL stay low and a pending wr_req SHALL remain un-serviced until RUN.
- REQ-025 Simultaneous reload and wr_req in RUN: reload wins, no write, no ack.
- REQ-026 wr_addr >= DEPTH SHALL be acknowledged but SHALL NOT modify memory.
- REQ-027 rd_q SHALL equal mem[rd_addr] registered, one-cycle latency, in both states; rd_addr >= DEPTH SHALL return 0.
- REQ-028 Read and write to the same address in one cycle SHALL return the old value (read-before-write).

Reset
- REQ-029 rst high SHALL asynchronously force state COPY, counter 0, ready 0, wr_ack 0, rd_q 0, rom_addr 0.
- REQ-030 Memory contents are not reset; the copy after rst deassertion SHALL overwrite all entries.
- REQ-031 rst asserted mid-copy or mid-write SHALL abort the operation with no ack issued.

Configuration
- REQ-032 Macro BKG_WALL_GUARD_EN: when defined, a write whose target entry currently holds code 6 (solid wall) SHALL be acknowledged but leave the entry unchanged; when undefined, all in-range writes are committed.

Verification
- REQ-033 Reset release with ROM model (entry 1 = 6, entry 0 = 0) -> ready low for 300 cycles, high on cycle 300; rd_addr=1 then rd_q=6 one cycle later.
- REQ-034 RUN, wr_req, wr_addr=0, wr_data=3 -> wr_ack one cycle; read addr 0 returns 3.
- REQ-035 wr_req held from reset -> no ack during COPY, ack on first RUN cycle, data committed.
- REQ-036 reload at copy cycle 150 -> ready stays low another 300 cycles; rom_addr restarts at 0.
- REQ-037 wr_addr=300 -> ack, no entry changed; rd_addr=300 -> rd_q=0.
- REQ-038 With BKG_WALL_GUARD_EN, write 0 to addr 1 (code 6) -> ack, read returns 6; without it, read returns 0.
